// File: rtl/cmul_arbiter_pkg.sv
// Shared definitions for the arbitrated complex multiplier:
// product width helper and requester-id constants.
package cmul_arbiter_pkg;

  // Requester ids, also used as values of the round-robin pointer.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Output width after dropping P fraction bits from a 2W+1 bit product.
  function automatic int cmul_out_width(input int w, input int p);
    return 2 * w - p + 1;
  endfunction

endpackage

// File: rtl/cmul_arbiter_complexmul.sv
// Combinational complex multiply: (Ar + jAi) * (Br + jBi).
// Full result is carried at 2W+1 bits, then the P fraction LSBs are
// dropped (floor toward -inf, no rounding, no saturation).
module complexMUL
  import cmul_arbiter_pkg::*;
#(
  parameter int p_inputWidth    = 16,
  parameter int p_PointPosition = 14
) (
  input  logic signed [p_inputWidth-1:0]                                   i_Ar,
  input  logic signed [p_inputWidth-1:0]                                   i_Ai,
  input  logic signed [p_inputWidth-1:0]                                   i_Br,
  input  logic signed [p_inputWidth-1:0]                                   i_Bi,
  output logic signed [cmul_out_width(p_inputWidth, p_PointPosition)-1:0] o_ResR,
  output logic signed [cmul_out_width(p_inputWidth, p_PointPosition)-1:0] o_ResI
);

  localparam int W  = p_inputWidth;
  localparam int P  = p_PointPosition;
  localparam int FW = 2 * W + 1;

  logic signed [2*W-1:0] prod_rr;
  logic signed [2*W-1:0] prod_ii;
  logic signed [2*W-1:0] prod_ri;
  logic signed [2*W-1:0] prod_ir;
  logic signed [FW-1:0]  full_r;
  logic signed [FW-1:0]  full_i;
  logic                  unused_frac;

  // Partial products, sign-extended sums, and fraction truncation.
  always_comb begin
    prod_rr = i_Ar * i_Br;
    prod_ii = i_Ai * i_Bi;
    prod_ri = i_Ar * i_Bi;
    prod_ir = i_Ai * i_Br;
    full_r  = {prod_rr[2*W-1], prod_rr} - {prod_ii[2*W-1], prod_ii};
    full_i  = {prod_ri[2*W-1], prod_ri} + {prod_ir[2*W-1], prod_ir};
    o_ResR  = full_r[2*W:P];
    o_ResI  = full_i[2*W:P];
  end

  // The dropped fraction bits are intentionally discarded.
  assign unused_frac = ^{full_r[P-1:0], full_i[P-1:0]};

endmodule

// File: rtl/cmul_arbiter.sv
// Two-requester round-robin arbiter feeding a 2-stage complex multiply
// pipeline with valid/ready on both sides.
// Optional feature macro: CMUL_ARB_CONJ_EN adds per-requester conj inputs
// that replace Bi with its saturated negation before multiplication.
module cmul_arbiter
  import cmul_arbiter_pkg::*;
#(
  parameter int p_inputWidth    = 16,
  parameter int p_PointPosition = 14
) (
  input  logic                                                             i_clk,
  input  logic                                                             i_rst,
  input  logic                                                             i_req0_valid,
  output logic                                                             o_req0_ready,
  input  logic signed [p_inputWidth-1:0]                                   i_req0_Ar,
  input  logic signed [p_inputWidth-1:0]                                   i_req0_Ai,
  input  logic signed [p_inputWidth-1:0]                                   i_req0_Br,
  input  logic signed [p_inputWidth-1:0]                                   i_req0_Bi,
  input  logic                                                             i_req1_valid,
  output logic                                                             o_req1_ready,
  input  logic signed [p_inputWidth-1:0]                                   i_req1_Ar,
  input  logic signed [p_inputWidth-1:0]                                   i_req1_Ai,
  input  logic signed [p_inputWidth-1:0]                                   i_req1_Br,
  input  logic signed [p_inputWidth-1:0]                                   i_req1_Bi,
`ifdef CMUL_ARB_CONJ_EN
  input  logic                                                             i_req0_conj,
  input  logic                                                             i_req1_conj,
`endif
  output logic                                                             o_valid,
  input  logic                                                             i_ready,
  output logic signed [cmul_out_width(p_inputWidth, p_PointPosition)-1:0] o_ResR,
  output logic signed [cmul_out_width(p_inputWidth, p_PointPosition)-1:0] o_ResI,
  output logic                                                             o_id,
  output logic                                                             o_busy
);

  localparam int W  = p_inputWidth;
  localparam int OW = cmul_out_width(p_inputWidth, p_PointPosition);

  logic                ptr;
  logic                gnt0;
  logic                gnt1;
  logic                adv1;
  logic                adv2;
  logic                accept;

  logic signed [W-1:0] sel_ar;
  logic signed [W-1:0] sel_ai;
  logic signed [W-1:0] sel_br;
  logic signed [W-1:0] sel_bi;
  logic                sel_id;

  logic                s1_valid;
  logic signed [W-1:0] s1_ar;
  logic signed [W-1:0] s1_ai;
  logic signed [W-1:0] s1_br;
  logic signed [W-1:0] s1_bi;
  logic                s1_id;

  logic                s2_valid;
  logic signed [OW-1:0] s2_resr;
  logic signed [OW-1:0] s2_resi;
  logic                s2_id;

  logic signed [OW-1:0] mul_resr;
  logic signed [OW-1:0] mul_resi;

`ifdef CMUL_ARB_CONJ_EN
  // Negation that maps the most negative code to the most positive one.
  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
    if (v == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    else
      return -v;
  endfunction
`endif

  // Pipeline advance and round-robin grant; readies are forced low in reset.
  always_comb begin
    adv2 = !s2_valid | i_ready;
    adv1 = !s1_valid | adv2;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ptr == REQ0) begin
      gnt0 = i_req0_valid;
      gnt1 = !i_req0_valid & i_req1_valid;
    end else begin
      gnt1 = i_req1_valid;
      gnt0 = !i_req1_valid & i_req0_valid;
    end
    o_req0_ready = gnt0 & adv1 & !i_rst;
    o_req1_ready = gnt1 & adv1 & !i_rst;
    accept       = o_req0_ready | o_req1_ready;
  end

  // Operand mux for the granted requester, with optional conjugation of B.
  always_comb begin
    sel_id = gnt1 ? REQ1 : REQ0;
    sel_ar = gnt1 ? i_req1_Ar : i_req0_Ar;
    sel_ai = gnt1 ? i_req1_Ai : i_req0_Ai;
    sel_br = gnt1 ? i_req1_Br : i_req0_Br;
`ifdef CMUL_ARB_CONJ_EN
    if (gnt1)
      sel_bi = i_req1_conj ? sat_neg(i_req1_Bi) : i_req1_Bi;
    else
      sel_bi = i_req0_conj ? sat_neg(i_req0_Bi) : i_req0_Bi;
`else
    sel_bi = gnt1 ? i_req1_Bi : i_req0_Bi;
`endif
  end

  // Priority pointer moves to the side that lost, only on an accepted pair.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      ptr <= REQ0;
    else if (accept)
      ptr <= o_req0_ready ? REQ1 : REQ0;
  end

  // Stage 1: capture the accepted operands and the issuing requester id.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_id    <= REQ0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_ar <= sel_ar;
        s1_ai <= sel_ai;
        s1_br <= sel_br;
        s1_bi <= sel_bi;
        s1_id <= sel_id;
      end
    end
  end

  complexMUL #(
    .p_inputWidth    (p_inputWidth),
    .p_PointPosition (p_PointPosition)
  ) u_cmul (
    .i_Ar   (s1_ar),
    .i_Ai   (s1_ai),
    .i_Br   (s1_br),
    .i_Bi   (s1_bi),
    .o_ResR (mul_resr),
    .o_ResI (mul_resi)
  );

  // Stage 2: capture the product; holds while the downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_resr  <= '0;
      s2_resi  <= '0;
      s2_id    <= REQ0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_resr <= mul_resr;
        s2_resi <= mul_resi;
        s2_id   <= s1_id;
      end
    end
  end

  assign o_valid = s2_valid;
  assign o_ResR  = s2_resr;
  assign o_ResI  = s2_resi;
  assign o_id    = s2_id;
  assign o_busy  = s1_valid | s2_valid;

endmodule
